// File: rtl/d_pipe.sv
// d_pipe: DEPTH-stage valid/ready register pipeline with synchronous flush.
// Define D_PIPE_OCC_EN to add the registered occupancy counter port.
module d_pipe #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
`ifdef D_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

  logic [WIDTH-1:0] data  [DEPTH];
  logic [WIDTH-1:0] src_d [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] src_v;
  logic [DEPTH-1:0] load;
  logic [DEPTH-1:0] drain;
  logic [DEPTH:0]   rdy;

  assign rdy[DEPTH] = out_ready;
  assign src_d[0]   = in;
  assign src_v[0]   = in_valid;

  // Stage k is ready when any stage at or after it is empty.
  for (genvar k = 0; k < DEPTH; k++) begin : gen_stage
    assign rdy[k]   = out_ready | ~(&valid[DEPTH-1:k]);
    assign load[k]  = src_v[k] & rdy[k] & ~flush;
    assign drain[k] = valid[k] & rdy[k+1];
  end

  for (genvar k = 1; k < DEPTH; k++) begin : gen_src
    assign src_d[k] = data[k-1];
    assign src_v[k] = valid[k-1];
  end

  assign in_ready  = rdy[0] & ~flush;
  assign out       = data[DEPTH-1];
  assign out_valid = valid[DEPTH-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      for (int k = 0; k < DEPTH; k++) data[k] <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (flush) begin
          valid[k] <= 1'b0;
        end else if (load[k]) begin
          valid[k] <= 1'b1;
          data[k]  <= src_d[k];
        end else if (drain[k]) begin
          valid[k] <= 1'b0;
        end
      end
    end
  end

`ifdef D_PIPE_OCC_EN
  localparam int OW = $clog2(DEPTH+1);

  logic          acc;
  logic          rel;
  logic [OW-1:0] occ_q;

  assign acc       = in_valid & in_ready;
  assign rel       = out_valid & out_ready;
  assign occupancy = occ_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else if (acc && !rel) begin
      occ_q <= occ_q + OW'(1);
    end else if (rel && !acc) begin
      occ_q <= occ_q - OW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_d_pipe.sv
// tb_d_pipe: scoreboard bench for d_pipe, DEPTH=4/WIDTH=16 and DEPTH=1/WIDTH=8.
// The reference holds accepted words in a queue; in_ready = !flush && (held<DEPTH || out_ready).
module tb_d_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  logic        r4, f4, iv4, ir4, ov4, or4;
  logic [15:0] d4, q4;
  logic        r1, f1, iv1, ir1, ov1, or1;
  logic [7:0]  d1, q1;
`ifdef D_PIPE_OCC_EN
  logic [2:0]  oc4;
  logic [0:0]  oc1;
`endif

  d_pipe #(.WIDTH(16), .DEPTH(4)) u4 (
    .clk(clk), .reset(r4), .flush(f4),
    .in(d4), .in_valid(iv4), .in_ready(ir4),
    .out(q4), .out_valid(ov4), .out_ready(or4)
`ifdef D_PIPE_OCC_EN
    , .occupancy(oc4)
`endif
  );

  d_pipe #(.WIDTH(8), .DEPTH(1)) u1 (
    .clk(clk), .reset(r1), .flush(f1),
    .in(d1), .in_valid(iv1), .in_ready(ir1),
    .out(q1), .out_valid(ov1), .out_ready(or1)
`ifdef D_PIPE_OCC_EN
    , .occupancy(oc1)
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- DEPTH=4 scoreboard ----------------
  logic [15:0] sb4[$];
  int          acyc4[$];
  bit          lat4 = 0;
  bit          hold4 = 0;
  logic [15:0] hold4_val;

  always @(negedge clk) begin
    logic [15:0] w;
    int a;
    if (r4 === 1'b1) begin
      if (hold4) begin
        chk("hold_valid4", ov4, 1);
        chk("hold_data4", q4, hold4_val);
      end
      hold4     = ov4 && !or4 && !f4;
      hold4_val = q4;
      if (ov4 && or4) begin
        if (sb4.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_out4: got %0h want none", q4);
        end else begin
          w = sb4.pop_front();
          a = acyc4.pop_front();
          chk("out4", q4, w);
          if (lat4) chk("lat4", cyc - a, 4);
        end
      end
      if (f4) begin
        sb4.delete();
        acyc4.delete();
      end
    end
  end

  task automatic step4(input bit iv, input logic [15:0] d,
                       input bit ordy, input bit fl);
    bit exp_ir;
    @(posedge clk);
    #1;
    iv4 = iv; d4 = d; or4 = ordy; f4 = fl;
    #2;
    exp_ir = !fl && (sb4.size() < 4 || ordy);
    chk("in_ready4", ir4, exp_ir);
`ifdef D_PIPE_OCC_EN
    chk("occ4", oc4, sb4.size());
`endif
    if (iv && exp_ir) begin
      sb4.push_back(d);
      acyc4.push_back(cyc);
    end
  endtask

  // ---------------- DEPTH=1 scoreboard ----------------
  logic [7:0] sb1[$];
  int  recv1 = 0;
  bit  done1 = 0;

  always @(negedge clk) begin
    if (r1 === 1'b1 && ov1 && or1) begin
      recv1++;
      if (sb1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_out1: got %0h want none", q1);
      end else begin
        chk("out1", q1, sb1.pop_front());
      end
    end
  end

  initial begin
    int n;
    bit exp_ir;
    r1 = 0; f1 = 0; iv1 = 0; or1 = 0; d1 = '0;
    repeat (2) @(negedge clk);
    r1 = 1;
    n = 0;
    for (int c = 0; c < 80 && n < 20; c++) begin
      @(posedge clk);
      #1;
      iv1 = 1; d1 = 8'($urandom); or1 = (c % 2 == 0);
      #2;
      exp_ir = (sb1.size() < 1) || or1;
      chk("in_ready1", ir1, exp_ir);
      if (exp_ir) begin
        sb1.push_back(d1);
        n++;
      end
    end
    @(posedge clk);
    #1;
    iv1 = 0; or1 = 1;
    repeat (4) @(posedge clk);
    #3;
    chk("count1", recv1, 20);
    chk("left1", sb1.size(), 0);
    done1 = 1;
  end

  // ---------------- DEPTH=4 directed + random ----------------
  initial begin
    logic [15:0] head;
    r4 = 0; f4 = 0; iv4 = 0; or4 = 0; d4 = '0;
    #3;
    chk("rst_out", q4, 0);
    chk("rst_ov", ov4, 0);
`ifdef D_PIPE_OCC_EN
    chk("rst_occ", oc4, 0);
`endif
    @(negedge clk);
    r4 = 1;
    step4(0, 0, 1, 0);
    chk("ir_after_rst", ir4, 1);

    lat4 = 1;
    for (int i = 1; i <= 8; i++) step4(1, 16'(i), 1, 0);
    repeat (6) step4(0, 0, 1, 0);
    lat4 = 0;

    for (int i = 0; i < 6; i++) step4(1, 16'($urandom), 0, 0);
    chk("full_ir", ir4, 0);
    step4(1, 16'hbeef, 1, 0);
    step4(0, 0, 0, 0);
    repeat (6) step4(0, 0, 1, 0);

    for (int i = 0; i < 3; i++) step4(1, 16'($urandom), 0, 0);
    step4(0, 0, 0, 0);
    head = sb4[0];
    step4(1, 16'h5555, 1, 1);
    step4(0, 0, 1, 0);
    chk("flush_ov", ov4, 0);
    chk("flush_out", q4, head);

    step4(1, 16'h1111, 0, 0);
    step4(1, 16'h2222, 0, 0);
    @(posedge clk);
    #1;
    iv4 = 0;
    #1;
    r4 = 0;
    #1;
    chk("mid_rst_out", q4, 0);
    chk("mid_rst_ov", ov4, 0);
    sb4.delete();
    acyc4.delete();
    hold4 = 0;
    @(negedge clk);
    r4 = 1;
    step4(0, 0, 1, 0);
    chk("ir_after_rst2", ir4, 1);
    lat4 = 1;
    step4(1, 16'h7a7a, 1, 0);
    repeat (6) step4(0, 0, 1, 0);
    lat4 = 0;

    for (int i = 0; i < 300; i++)
      step4(1'($urandom % 2), 16'($urandom),
            ($urandom % 4) != 0, ($urandom % 24) == 0);
    repeat (8) step4(0, 0, 1, 0);
    chk("drain4", sb4.size(), 0);

    for (int i = 0; i < 100 && !done1; i++) @(posedge clk);
    chk("done1", done1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/d_pipe.md
D_PIPE -- requirements
Module: d_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning data width in bits (legal 1..64).
REQ-002 SHALL have parameter DEPTH, default 4, meaning number of register stages (legal 1..16).
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 SHALL have port flush  input  1  synchronous discard of all held words.
REQ-006 SHALL have port in  input  WIDTH  upstream data word.
REQ-007 SHALL have port in_valid  input  1  upstream word present.
REQ-008 SHALL have port in_ready  output  1  pipe accepts a word this cycle.
REQ-009 SHALL have port out  output  WIDTH  downstream data word (stage DEPTH-1 register).
REQ-010 SHALL have port out_valid  output  1  out holds a valid word.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the word this cycle.
REQ-012 SHALL have port occupancy  output  $clog2(DEPTH+1)  count of valid stages (present only under D_PIPE_OCC_EN).

Function
REQ-013 SHALL implement DEPTH stages, each a WIDTH-bit data register plus one valid bit; stage 0 is fed from in, and stage DEPTH-1 drives out/out_valid.
REQ-014 SHALL define stage k ready as (!valid[k] || ready[k+1]); ready[DEPTH] = out_ready; in_ready = ready[0] && !flush.
REQ-015 SHALL transfer a word into stage k at a rising edge when its source is valid and ready[k] = 1; the source stage clears valid unless it is refilled in the same edge.
REQ-016 SHALL accept an input word only when in_valid && in_ready at a rising edge, and complete an output transfer only when out_valid && out_ready.
REQ-017 SHALL deliver an accepted word on out exactly DEPTH cycles after acceptance when out_ready is held 1; sustained throughput SHALL be one word per cycle.
REQ-018 SHALL hold out and out_valid stable while out_valid && !out_ready; no word SHALL be dropped, duplicated or reordered.
REQ-019 SHALL, when all stages are valid and out_ready = 0, drive in_ready = 0 (full); a simultaneous out_ready = 1 on a full pipe SHALL allow acceptance in the same cycle.
REQ-020 SHALL, on a rising edge with flush = 1, clear every valid bit; an output transfer handshaken in that cycle counts as completed, and no input is accepted.
REQ-021 SHALL leave data registers unchanged on flush; only valid bits are cleared.
REQ-022 SHALL, for DEPTH = 1, behave as a single registered stage with in_ready = (!out_valid || out_ready) && !flush.

Reset
REQ-023 SHALL, while reset = 0, asynchronously clear all valid bits and all data registers to 0, giving out = 0, out_valid = 0, and occupancy = 0.
REQ-024 SHALL, on reset asserted mid-transfer, discard all held words; the first word accepted after release emerges after DEPTH cycles.
REQ-025 SHALL drive in_ready = 1 in the first cycle after reset release when flush = 0.

Configuration
REQ-026 SHALL, with macro D_PIPE_OCC_EN defined, provide the occupancy port as a registered count, updated each edge by +1 on accept-only, -1 on output-only, unchanged on both or neither, and 0 after flush, or 1 after flush if an input is accepted in the same edge (impossible by REQ-014, so 0).
REQ-027 SHALL, without D_PIPE_OCC_EN, omit the occupancy port and its counter entirely, with all other behaviour identical.

Verification
REQ-028 SHALL cover: WIDTH=16, DEPTH=4, out_ready=1, input words 0x0001..0x0008 on consecutive cycles -> out 0x0001..0x0008 on consecutive cycles, first word 4 cycles after acceptance.
REQ-029 SHALL cover: DEPTH=4, out_ready=0, in_valid=1 for 6 cycles -> 4 words accepted, in_ready=0 thereafter, occupancy=4; then out_ready=1 -> words drained in order.
REQ-030 SHALL cover: full pipe, out_ready=1, in_valid=1 same cycle -> one word out, one word in, occupancy stays 4.
REQ-031 SHALL cover: 3 words held, flush=1 for one cycle with out_ready=1 -> head word transferred, out_valid=0 next cycle, occupancy=0, out retains last data value.
REQ-032 SHALL cover: reset driven 0 between clock edges with 2 words held -> out=0x0000 and out_valid=0 immediately; in_ready=1 first cycle after release.
REQ-033 SHALL cover: DEPTH=1, WIDTH=8, alternating out_ready 1/0 with continuous in_valid -> no loss or duplication across 20 words (scoreboard match).
